sys_reset_sequencer: RTL and testbench

Power-up and reset sequencer for the system PLL and the downstream clock-domain consumers: sensor capture, SDRAM frame buffer, frame-difference core and VGA output. It holds the PLL in reset after power-up, waits for a stable, debounced `locked`, then releases per-stage active-low resets in a fixed order with programmable gaps. It also handles lock timeouts, lock loss and software re-sync requests by re-running the sequence. It sits on the board input clock next to the PLL instance and drives its `areset`.

---
 rtl/sys_rst_seq_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/sys_reset_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sys_reset_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_rst_seq_pkg.sv
// Shared types and widths for the system reset sequencer.
// Holds the sequencer state encoding and a saturating fail-counter helper.
package sys_rst_seq_pkg;

   localparam int RST_SEQ_CNT_W  = 24;
   localparam int RST_SEQ_FAIL_W = 4;

   typedef enum logic [2:0] {
      PWRUP     = 3'd0,
      PLL_RST   = 3'd1,
      WAIT_LOCK = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } rst_seq_state_t;

   // Lock-failure counter sticks at all-ones instead of wrapping.
   function automatic logic [RST_SEQ_FAIL_W-1:0] fail_sat_inc(
      input logic [RST_SEQ_FAIL_W-1:0] val
   );
      logic [RST_SEQ_FAIL_W-1:0] res;
      if (val == {RST_SEQ_FAIL_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(RST_SEQ_FAIL_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous status inputs.
// Clears to 0 on the synchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;

   // Two-stage resynchronisation of d into the clk domain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/sys_reset_sequencer.sv
// PLL power-up and staged reset-release sequencer on the board clock.
// Optional macro RST_SEQ_LOCK_MONITOR_EN: lock loss while in RUN restarts the sequence.
module sys_reset_sequencer
   import sys_rst_seq_pkg::*;
#(
   parameter int unsigned                NUM_STAGES         = 4,
   parameter logic [RST_SEQ_CNT_W-1:0]   POWERUP_CYCLES     = 24'd2500000,
   parameter logic [RST_SEQ_CNT_W-1:0]   PLL_RST_CYCLES     = 24'd16,
   parameter logic [RST_SEQ_CNT_W-1:0]   LOCK_STABLE_CYCLES = 24'd1024,
   parameter logic [RST_SEQ_CNT_W-1:0]   LOCK_TIMEOUT       = 24'd1000000,
   parameter logic [RST_SEQ_CNT_W-1:0]   STAGE_GAP          = 24'd256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pll_locked,
   input  logic                       resync_req,
   output logic                       pll_areset,
   output logic [NUM_STAGES-1:0]      stage_rst_n,
   output logic                       sys_ready,
   output logic [RST_SEQ_FAIL_W-1:0]  lock_fail_cnt
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [RST_SEQ_CNT_W-1:0] CNT_ZERO = {RST_SEQ_CNT_W{1'b0}};
   localparam logic [RST_SEQ_CNT_W-1:0] CNT_ONE  = {{(RST_SEQ_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]         IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]         IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(NUM_STAGES - 1);

   rst_seq_state_t             state_r;
   rst_seq_state_t             state_nxt_s;
   logic [RST_SEQ_CNT_W-1:0]   cnt_r;
   logic [RST_SEQ_CNT_W-1:0]   cnt_nxt_s;
   logic [RST_SEQ_CNT_W-1:0]   stable_cnt_r;
   logic [RST_SEQ_CNT_W-1:0]   stable_nxt_s;
   logic [IDX_W-1:0]           stage_idx_r;
   logic [IDX_W-1:0]           idx_nxt_s;
   logic                       fail_event_s;
   logic                       locked_s;
   logic                       areset_nxt_s;
   logic                       ready_nxt_s;
   logic [NUM_STAGES-1:0]      stage_nxt_s;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Next-state, counter and failure-event decode. cnt_r is the per-state cycle counter.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r + CNT_ONE;
      stable_nxt_s = CNT_ZERO;
      idx_nxt_s    = stage_idx_r;
      fail_event_s = 1'b0;
      case (state_r)
         PWRUP: begin
            if (cnt_r == POWERUP_CYCLES - CNT_ONE) begin
               state_nxt_s = PLL_RST;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = PWRUP;
            end
         end
         PLL_RST: begin
            if (cnt_r == PLL_RST_CYCLES - CNT_ONE) begin
               state_nxt_s = WAIT_LOCK;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               state_nxt_s = PLL_RST;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               stable_nxt_s = stable_cnt_r + CNT_ONE;
            end else begin
               stable_nxt_s = CNT_ZERO;
            end
            // A lock that becomes stable on the timeout cycle still counts as success.
            if (locked_s && (stable_cnt_r == LOCK_STABLE_CYCLES - CNT_ONE)) begin
               state_nxt_s  = RELEASE;
               cnt_nxt_s    = CNT_ZERO;
               stable_nxt_s = CNT_ZERO;
               idx_nxt_s    = IDX_ZERO;
            end else if (cnt_r == LOCK_TIMEOUT - CNT_ONE) begin
               state_nxt_s  = PLL_RST;
               cnt_nxt_s    = CNT_ZERO;
               stable_nxt_s = CNT_ZERO;
               fail_event_s = 1'b1;
            end else begin
               state_nxt_s = WAIT_LOCK;
            end
         end
         RELEASE: begin
            if (!locked_s) begin
               state_nxt_s  = PLL_RST;
               cnt_nxt_s    = CNT_ZERO;
               idx_nxt_s    = IDX_ZERO;
               fail_event_s = 1'b1;
            end else if (cnt_r == STAGE_GAP - CNT_ONE) begin
               cnt_nxt_s = CNT_ZERO;
               if (stage_idx_r == IDX_LAST) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = RELEASE;
                  idx_nxt_s   = stage_idx_r + IDX_ONE;
               end
            end else begin
               state_nxt_s = RELEASE;
            end
         end
         RUN: begin
            cnt_nxt_s = CNT_ZERO;
`ifdef RST_SEQ_LOCK_MONITOR_EN
            if (!locked_s) begin
               state_nxt_s  = PLL_RST;
               idx_nxt_s    = IDX_ZERO;
               fail_event_s = 1'b1;
            end else if (resync_req) begin
               state_nxt_s = PLL_RST;
               idx_nxt_s   = IDX_ZERO;
            end else begin
               state_nxt_s = RUN;
            end
`else
            if (resync_req) begin
               state_nxt_s = PLL_RST;
               idx_nxt_s   = IDX_ZERO;
            end else begin
               state_nxt_s = RUN;
            end
`endif
         end
         default: begin
            state_nxt_s = PWRUP;
            cnt_nxt_s   = CNT_ZERO;
            idx_nxt_s   = IDX_ZERO;
         end
      endcase
   end

   // Output decode from the next state so outputs change in the first cycle of a new state.
   always_comb begin
      stage_nxt_s  = {NUM_STAGES{1'b0}};
      areset_nxt_s = 1'b0;
      ready_nxt_s  = 1'b0;
      if ((state_nxt_s == PWRUP) || (state_nxt_s == PLL_RST)) begin
         areset_nxt_s = 1'b1;
      end else begin
         areset_nxt_s = 1'b0;
      end
      if (state_nxt_s == RUN) begin
         stage_nxt_s = {NUM_STAGES{1'b1}};
         ready_nxt_s = 1'b1;
      end else if (state_nxt_s == RELEASE) begin
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_nxt_s[i] = (32'(idx_nxt_s) >= i);
         end
      end else begin
         stage_nxt_s = {NUM_STAGES{1'b0}};
         ready_nxt_s = 1'b0;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= PWRUP;
         cnt_r         <= CNT_ZERO;
         stable_cnt_r  <= CNT_ZERO;
         stage_idx_r   <= IDX_ZERO;
         pll_areset    <= 1'b1;
         stage_rst_n   <= {NUM_STAGES{1'b0}};
         sys_ready     <= 1'b0;
         lock_fail_cnt <= {RST_SEQ_FAIL_W{1'b0}};
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         stable_cnt_r <= stable_nxt_s;
         stage_idx_r  <= idx_nxt_s;
         pll_areset   <= areset_nxt_s;
         stage_rst_n  <= stage_nxt_s;
         sys_ready    <= ready_nxt_s;
         if (fail_event_s) begin
            lock_fail_cnt <= fail_sat_inc(lock_fail_cnt);
         end else begin
            lock_fail_cnt <= lock_fail_cnt;
         end
      end
   end

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Self-checking bench for sys_reset_sequencer: directed scenarios plus random lock/resync/reset
// traffic, all compared every cycle against a phase/elapsed-time reference model.
module tb_sys_reset_sequencer;

   localparam int NS   = 3;
   localparam int PWR  = 16;
   localparam int PRST = 4;
   localparam int STB  = 8;
   localparam int TMO  = 64;
   localparam int GAP  = 4;

   localparam int PH_PWR  = 0;
   localparam int PH_PRST = 1;
   localparam int PH_WAIT = 2;
   localparam int PH_REL  = 3;
   localparam int PH_RUN  = 4;

`ifdef RST_SEQ_LOCK_MONITOR_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_locked = 1'b0;
   logic          resync_req = 1'b0;
   logic          pll_areset;
   logic [NS-1:0] stage_rst_n;
   logic          sys_ready;
   logic [3:0]    lock_fail_cnt;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int base = 0;
   int t;
   logic lvl;

   // reference model: phase, cycle the phase began, failures, last cycle locked_s was 0
   int   m_ph, m_start, m_fail, m_lastzero;
   logic m_d1, m_d2;

   always #5 clk = ~clk;

   sys_reset_sequencer #(
      .NUM_STAGES         (NS),
      .POWERUP_CYCLES     (24'd16),
      .PLL_RST_CYCLES     (24'd4),
      .LOCK_STABLE_CYCLES (24'd8),
      .LOCK_TIMEOUT       (24'd64),
      .STAGE_GAP          (24'd4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .resync_req    (resync_req),
      .pll_areset    (pll_areset),
      .stage_rst_n   (stage_rst_n),
      .sys_ready     (sys_ready),
      .lock_fail_cnt (lock_fail_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s @t=%0d: observed %0h expected %0h", tag, cyc - base, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ph       = PH_PWR;
      m_start    = cyc + 1;
      m_fail     = 0;
      m_lastzero = cyc;
      m_d1       = 1'b0;
      m_d2       = 1'b0;
   endtask

   // Advance the model across the clock edge that ends cycle `cyc`.
   task automatic model_step(input logic lk, input logic rq, input logic rn);
      int   el, from, ones, nph;
      bit   go;
      logic ls;
      if (!rn) begin
         model_reset();
      end else begin
         ls = m_d2;
         el = cyc - m_start;
         if (!ls) m_lastzero = cyc;
         from = (m_lastzero > m_start - 1) ? m_lastzero : m_start - 1;
         ones = cyc - from;
         go   = 1'b0;
         nph  = m_ph;
         case (m_ph)
            PH_PWR:  if (el == PWR - 1) begin go = 1'b1; nph = PH_PRST; end
            PH_PRST: if (el == PRST - 1) begin go = 1'b1; nph = PH_WAIT; end
            PH_WAIT: begin
               if (ls && ones == STB) begin go = 1'b1; nph = PH_REL; end
               else if (el == TMO - 1) begin
                  go = 1'b1; nph = PH_PRST;
                  if (m_fail < 15) m_fail++;
               end
            end
            PH_REL: begin
               if (!ls) begin
                  go = 1'b1; nph = PH_PRST;
                  if (m_fail < 15) m_fail++;
               end else if (el == NS * GAP - 1) begin
                  go = 1'b1; nph = PH_RUN;
               end
            end
            PH_RUN: begin
               if (MON && !ls) begin
                  go = 1'b1; nph = PH_PRST;
                  if (m_fail < 15) m_fail++;
               end else if (rq) begin
                  go = 1'b1; nph = PH_PRST;
               end
            end
            default: begin go = 1'b1; nph = PH_PWR; end
         endcase
         if (go) begin
            m_ph    = nph;
            m_start = cyc + 1;
         end
         m_d2 = m_d1;
         m_d1 = lk;
      end
   endtask

   // Drive one cycle's inputs, compare outputs mid-cycle, then step across the edge.
   task automatic run_cycle(input logic lk, input logic rq, input logic rn);
      logic [NS-1:0] e_stage;
      pll_locked = lk;
      resync_req = rq;
      rst_n      = rn;
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         e_stage[i] = (m_ph == PH_RUN) || ((m_ph == PH_REL) && ((cyc - m_start) >= i * GAP));
      end
      chk("model_areset", 32'(pll_areset), 32'(m_ph == PH_PWR || m_ph == PH_PRST));
      chk("model_stage", 32'(stage_rst_n), 32'(e_stage));
      chk("model_ready", 32'(sys_ready), 32'(m_ph == PH_RUN));
      chk("model_fail", 32'(lock_fail_cnt), 32'(m_fail));
      @(posedge clk);
      model_step(lk, rq, rn);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      run_cycle(1'b0, 1'b0, 1'b0);
      base = cyc;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      cyc = 0;
      base = 0;
      model_reset();
      m_start = 0;
      chk("rst_areset", 32'(pll_areset), 32'd1);
      chk("rst_stage", 32'(stage_rst_n), 32'd0);
      chk("rst_ready", 32'(sys_ready), 32'd0);
      chk("rst_fail", 32'(lock_fail_cnt), 32'd0);

      // normal bring-up, then a one-cycle resync request in RUN
      while (cyc - base < 100) begin
         t = cyc - base;
         run_cycle(t >= 20, t == 60, 1'b1);
         t = cyc - base;
         if (t == 19) chk("s1_areset_hi", 32'(pll_areset), 32'd1);
         if (t == 20) chk("s1_areset_fall", 32'(pll_areset), 32'd0);
         if (t == 29) chk("s1_stage_none", 32'(stage_rst_n), 32'd0);
         if (t == 30) chk("s1_stage0", 32'(stage_rst_n), 32'd1);
         if (t == 34) chk("s1_stage1", 32'(stage_rst_n), 32'd3);
         if (t == 38) chk("s1_stage2", 32'(stage_rst_n), 32'd7);
         if (t == 41) chk("s1_ready_lo", 32'(sys_ready), 32'd0);
         if (t == 42) chk("s1_ready_hi", 32'(sys_ready), 32'd1);
         if (t == 61) begin
            chk("s5_stage", 32'(stage_rst_n), 32'd0);
            chk("s5_areset", 32'(pll_areset), 32'd1);
            chk("s5_fail", 32'(lock_fail_cnt), 32'd0);
         end
      end
      chk("s5_resequenced", 32'(sys_ready), 32'd1);

      // lock never arrives: repeated timeouts
      do_reset();
      while (cyc - base < 160) begin
         run_cycle(1'b0, 1'b0, 1'b1);
         t = cyc - base;
         if (t == 83) chk("s2_areset_lo", 32'(pll_areset), 32'd0);
         if (t == 84) chk("s2_areset_rerise", 32'(pll_areset), 32'd1);
         if (t == 84) chk("s2_fail1", 32'(lock_fail_cnt), 32'd1);
         if (t == 88) chk("s2_areset_fall2", 32'(pll_areset), 32'd0);
         if (t == 152) chk("s2_fail2", 32'(lock_fail_cnt), 32'd2);
      end

      // single-cycle lock glitch delays release
      do_reset();
      while (cyc - base < 50) begin
         t = cyc - base;
         run_cycle((t >= 20) && (t != 25), 1'b0, 1'b1);
         t = cyc - base;
         if (t == 30) chk("s3_no_release", 32'(stage_rst_n), 32'd0);
         if (t == 36) chk("s3_stage0", 32'(stage_rst_n), 32'd1);
      end

      // lock loss while in RUN
      do_reset();
      while (cyc - base < 60) begin
         t = cyc - base;
         run_cycle((t >= 20) && (t < 50), 1'b0, 1'b1);
         t = cyc - base;
         if (t == 52) chk("s4_ready_before", 32'(sys_ready), 32'd1);
         if (t == 53) begin
            chk("s4_ready", 32'(sys_ready), MON ? 32'd0 : 32'd1);
            chk("s4_stage", 32'(stage_rst_n), MON ? 32'd0 : 32'd7);
            chk("s4_areset", 32'(pll_areset), MON ? 32'd1 : 32'd0);
            chk("s4_fail", 32'(lock_fail_cnt), MON ? 32'd1 : 32'd0);
         end
      end

      // reset mid-RELEASE
      do_reset();
      while (cyc - base < 70) begin
         t = cyc - base;
         run_cycle(t >= 20, 1'b0, t != 35);
         t = cyc - base;
         if (t == 35) chk("s6_stage_pre", 32'(stage_rst_n), 32'd3);
         if (t == 36) begin
            chk("s6_areset", 32'(pll_areset), 32'd1);
            chk("s6_stage", 32'(stage_rst_n), 32'd0);
            chk("s6_ready", 32'(sys_ready), 32'd0);
            chk("s6_fail", 32'(lock_fail_cnt), 32'd0);
         end
         if (t == 56) chk("s6_areset_fall", 32'(pll_areset), 32'd0);
      end

      // failure counter saturation
      do_reset();
      while (cyc - base < 1110) begin
         run_cycle(1'b0, 1'b0, 1'b1);
         t = cyc - base;
         if (t == 1035) chk("sat_fail14", 32'(lock_fail_cnt), 32'd14);
         if (t == 1036) chk("sat_fail15", 32'(lock_fail_cnt), 32'd15);
         if (t == 1104) chk("sat_hold15", 32'(lock_fail_cnt), 32'd15);
      end

      // randomized lock wander, glitches, resync requests and occasional resets
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         lvl = 1'b0;
         for (int k = 0; k < 700; k++) begin
            if (lvl ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 14) == 0)) lvl = ~lvl;
            run_cycle(lvl ^ ($urandom_range(0, 63) == 0),
                      $urandom_range(0, 79) == 0,
                      $urandom_range(0, 399) != 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
